stage_mem: RTL and testbench

- Memory-access stage; sits directly downstream of the execute stage, behind the ex/mem pipeline latch.
- Consumes the execute stage's opcode, funct3, effective address, destination register, write-enable and write data.
- Performs LOAD/STORE over the shared byte-wide memory port as a byte-serial state machine, holding the pipeline via a stall request.
- Passes all non-memory results through to mem/wb.

---
 rtl/stage_mem_pkg.sv | 34 +++
 rtl/stage_mem_load_ext.sv | 21 ++
 rtl/stage_mem.sv | 147 ++++++++++++++
 tb/tb_stage_mem.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// rtl/stage_mem_pkg.sv - shared opcodes, funct3 codes, FSM encodings and byte counts for the memory stage
package stage_mem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_BUSY = 2'd1;
    localparam logic [1:0] MEM_DONE = 2'd2;

    localparam logic [2:0] NBYTES_B = 3'd1;
    localparam logic [2:0] NBYTES_H = 3'd2;
    localparam logic [2:0] NBYTES_W = 3'd4;

    // Access size from funct3[1:0]; the 2'b11 code is caught by the caller as illegal.
    function automatic logic [2:0] mem_nbytes(input logic [1:0] size);
        case (size)
            2'b00:   mem_nbytes = NBYTES_B;
            2'b01:   mem_nbytes = NBYTES_H;
            default: mem_nbytes = NBYTES_W;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_load_ext.sv
// rtl/stage_mem_load_ext.sv - sign/zero extension of the assembled load word
module mem_load_ext
    import stage_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ext_o
);

    // Pick the extension rule from the load's funct3.
    always_comb begin
        case (funct3_i)
            F3_LB:   ext_o = {{24{word_i[7]}}, word_i[7:0]};
            F3_LH:   ext_o = {{16{word_i[15]}}, word_i[15:0]};
            F3_LBU:  ext_o = {24'h000000, word_i[7:0]};
            F3_LHU:  ext_o = {16'h0000, word_i[15:0]};
            default: ext_o = word_i;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - memory-access stage with byte-serial LOAD/STORE over a shared byte port
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 3
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic                  mem_gnt_i,
    input  logic [7:0]            mem_rdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_wdata_o,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stall_req_o
);

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_issue;
    logic [CNT_WIDTH-1:0]  r_recv;
    logic                  r_store;
    logic [2:0]            r_funct3;
    logic                  r_rd_pend;
    logic [31:0]           r_word;

    logic [1:0]            w_state_nxt;
    logic [CNT_WIDTH-1:0]  w_nbytes;
    logic [CNT_WIDTH-1:0]  w_issue_nxt;
    logic [CNT_WIDTH-1:0]  w_recv_nxt;
    logic                  w_memop;
    logic                  w_illegal;
    logic                  w_start;
    logic                  w_req;
    logic                  w_grant;
    logic [31:0]           w_ext;

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_a;
    logic [7:0]            w_bwdata;
    logic [4:0]            w_wd;
    logic                  w_wreg;
    logic [31:0]           w_wdata;
    logic                  w_stall;

    mem_load_ext u_load_ext (
        .word_i   (r_word),
        .funct3_i (r_funct3),
        .ext_o    (w_ext)
    );

    assign w_illegal   = ((opcode_i == OPC_LOAD) || (opcode_i == OPC_STORE)) && (funct3_i[1:0] == 2'b11);
    assign w_memop     = ((opcode_i == OPC_LOAD) || (opcode_i == OPC_STORE)) && !w_illegal;
    assign w_start     = (r_state == MEM_IDLE) && w_memop && rdy;
    assign w_nbytes    = CNT_WIDTH'(mem_nbytes(r_funct3[1:0]));
    assign w_req       = (r_state == MEM_BUSY) && rdy && (r_issue < w_nbytes);
    assign w_grant     = w_req && mem_gnt_i;
    assign w_issue_nxt = r_issue + {{(CNT_WIDTH-1){1'b0}}, w_grant};
    assign w_recv_nxt  = r_recv + {{(CNT_WIDTH-1){1'b0}}, r_rd_pend};

    // Next-state selection and the stage's combinational outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_a         = '0;
        w_bwdata    = 8'h00;
        w_wd        = wd_i;
        w_wreg      = 1'b0;
        w_wdata     = 32'h0;
        w_stall     = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (w_memop) begin
                    w_stall = 1'b1;
                    if (rdy) w_state_nxt = MEM_BUSY;
                end else begin
                    w_wreg  = wreg_i && !w_illegal;
                    w_wdata = wdata_i;
                end
            end
            MEM_BUSY: begin
                w_stall  = 1'b1;
                w_we     = r_store;
                w_a      = mem_addr_i + {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, r_issue};
                w_bwdata = wdata_i[{r_issue[1:0], 3'b000} +: 8];
                if (rdy && ((r_store ? w_issue_nxt : w_recv_nxt) == w_nbytes))
                    w_state_nxt = MEM_DONE;
            end
            MEM_DONE: begin
                if (!r_store) begin
                    w_wreg  = wreg_i;
                    w_wdata = w_ext;
                end
                if (rdy) w_state_nxt = MEM_IDLE;
            end
            default: w_state_nxt = MEM_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so an aborted access releases the port at once.
    assign mem_req_o   = rst && w_req;
    assign mem_we_o    = rst && w_req && w_we;
    assign mem_a_o     = rst ? w_a      : '0;
    assign mem_wdata_o = rst ? w_bwdata : 8'h00;
    assign wd_o        = rst ? w_wd     : 5'd0;
    assign wreg_o      = rst && w_wreg;
    assign wdata_o     = rst ? w_wdata  : 32'h0;
    assign stall_req_o = rst && w_stall;

    // FSM, byte counters, read-return capture and per-access context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= MEM_IDLE;
            r_issue   <= '0;
            r_recv    <= '0;
            r_store   <= 1'b0;
            r_funct3  <= 3'b000;
            r_rd_pend <= 1'b0;
            r_word    <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_issue   <= w_issue_nxt;
            r_recv    <= w_recv_nxt;
            r_rd_pend <= w_grant && !r_store;
            if (r_rd_pend)
                r_word[{r_recv[1:0], 3'b000} +: 8] <= mem_rdata_i;
            if (w_start) begin
                r_issue  <= '0;
                r_recv   <= '0;
                r_word   <= 32'h0;
                r_store  <= (opcode_i == OPC_STORE);
                r_funct3 <= funct3_i;
            end
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - directed self-checking bench for stage_mem
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] mem_addr_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        mem_gnt_i;
    logic [7:0]  mem_rdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] alog_addr [0:63];
    logic [7:0]  alog_data [0:63];
    int          acount = 0;
    logic [7:0]  pend_data = 8'h00;

    int base;
    int lat;

    stage_mem #(.ADDR_WIDTH(32), .CNT_WIDTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .mem_addr_i  (mem_addr_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_a_o     (mem_a_o),
        .mem_wdata_o (mem_wdata_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: rom = 8'h78;
            32'h101: rom = 8'h56;
            32'h102: rom = 8'h34;
            32'h103: rom = 8'h12;
            32'h020: rom = 8'h80;
            32'h040: rom = 8'h01;
            32'h041: rom = 8'h80;
            default: rom = 8'h00;
        endcase
    endfunction

    // Byte-port memory: logs every granted access, returns read data the cycle after the grant.
    always @(negedge clk) begin
        mem_rdata_i = pend_data;
        pend_data   = 8'h00;
        if (mem_req_o === 1'b1 && mem_gnt_i === 1'b1) begin
            if (acount < 64) begin
                alog_addr[acount] = mem_a_o;
                alog_data[acount] = mem_we_o ? mem_wdata_o : 8'h00;
                acount = acount + 1;
            end
            if (mem_we_o !== 1'b1) pend_data = rom(mem_a_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                             input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
        opcode_i   = op;
        funct3_i   = f3;
        mem_addr_i = a;
        wd_i       = wd;
        wreg_i     = wr;
        wdata_i    = wdat;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (stall_req_o === 1'b1 && cyc < 40) begin
            step();
            cyc = cyc + 1;
        end
    endtask

    task automatic next_op();
        step();
        set_instr(OPC_OP, 3'b000, 32'h0, 5'd1, 1'b1, 32'hCAFE0001);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        mem_gnt_i = 1'b0;
        set_instr(OPC_OP, 3'b000, 32'h0, 5'd7, 1'b1, 32'h1234);
        #2;
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_wreg", {31'b0, wreg_o}, 32'h0);
        chk("rst_wd", {27'b0, wd_o}, 32'h0);
        chk("rst_stall", {31'b0, stall_req_o}, 32'h0);
        chk("rst_req", {31'b0, mem_req_o}, 32'h0);
        step();
        step();
        rst = 1'b1;

        set_instr(OPC_OP, 3'b000, 32'h0, 5'd5, 1'b1, 32'h1234);
        #1;
        chk("pt_wd", {27'b0, wd_o}, 32'd5);
        chk("pt_wreg", {31'b0, wreg_o}, 32'd1);
        chk("pt_wdata", wdata_o, 32'h1234);
        chk("pt_stall", {31'b0, stall_req_o}, 32'd0);
        chk("pt_req", {31'b0, mem_req_o}, 32'd0);

        step();
        mem_gnt_i = 1'b1;
        base = acount;
        set_instr(OPC_LOAD, F3_LW, 32'h100, 5'd3, 1'b1, 32'h0);
        #1;
        chk("lw_c0_stall", {31'b0, stall_req_o}, 32'd1);
        chk("lw_c0_wreg", {31'b0, wreg_o}, 32'd0);
        wait_done(lat);
        chk("lw_latency", lat, 32'd6);
        chk("lw_wdata", wdata_o, 32'h12345678);
        chk("lw_wreg", {31'b0, wreg_o}, 32'd1);
        chk("lw_wd", {27'b0, wd_o}, 32'd3);
        chk("lw_nacc", acount - base, 32'd4);
        for (int i = 0; i < 4; i++)
            chk("lw_addr", alog_addr[base + i], 32'h100 + i);
        next_op();
        chk("lw_no_retrigger", {31'b0, stall_req_o}, 32'd0);
        chk("lw_after_wdata", wdata_o, 32'hCAFE0001);

        step();
        set_instr(OPC_LOAD, F3_LB, 32'h20, 5'd4, 1'b1, 32'h0);
        #1;
        wait_done(lat);
        chk("lb_latency", lat, 32'd3);
        chk("lb_wdata", wdata_o, 32'hFFFFFF80);
        next_op();

        step();
        set_instr(OPC_LOAD, F3_LBU, 32'h20, 5'd4, 1'b1, 32'h0);
        #1;
        wait_done(lat);
        chk("lbu_latency", lat, 32'd3);
        chk("lbu_wdata", wdata_o, 32'h00000080);
        next_op();

        step();
        set_instr(OPC_LOAD, F3_LH, 32'h40, 5'd4, 1'b1, 32'h0);
        #1;
        wait_done(lat);
        chk("lh_latency", lat, 32'd4);
        chk("lh_wdata", wdata_o, 32'hFFFF8001);
        next_op();

        step();
        base = acount;
        set_instr(OPC_STORE, F3_SH, 32'hFFFFFFFF, 5'd9, 1'b1, 32'hAABBCCDD);
        #1;
        wait_done(lat);
        chk("sh_latency", lat, 32'd3);
        chk("sh_wreg", {31'b0, wreg_o}, 32'd0);
        chk("sh_wdata", wdata_o, 32'd0);
        chk("sh_nacc", acount - base, 32'd2);
        chk("sh_a0", alog_addr[base], 32'hFFFFFFFF);
        chk("sh_d0", {24'b0, alog_data[base]}, 32'hDD);
        chk("sh_a1", alog_addr[base + 1], 32'h00000000);
        chk("sh_d1", {24'b0, alog_data[base + 1]}, 32'hCC);
        next_op();

        step();
        base = acount;
        set_instr(OPC_LOAD, 3'b011, 32'h100, 5'd6, 1'b1, 32'h55);
        #1;
        chk("ill_stall", {31'b0, stall_req_o}, 32'd0);
        chk("ill_wreg", {31'b0, wreg_o}, 32'd0);
        chk("ill_wdata", wdata_o, 32'h55);
        chk("ill_req", {31'b0, mem_req_o}, 32'd0);

        step();
        base = acount;
        set_instr(OPC_STORE, F3_SW, 32'h200, 5'd2, 1'b1, 32'h44332211);
        #1;
        step();
        step();
        mem_gnt_i = 1'b0;
        #1;
        chk("sw_c2_req", {31'b0, mem_req_o}, 32'd1);
        chk("sw_c2_addr", mem_a_o, 32'h201);
        step();
        step();
        mem_gnt_i = 1'b1;
        step();
        rdy = 1'b0;
        #1;
        chk("sw_c5_req", {31'b0, mem_req_o}, 32'd0);
        chk("sw_c5_stall", {31'b0, stall_req_o}, 32'd1);
        step();
        rdy = 1'b1;
        step();
        chk("sw_c7_stall", {31'b0, stall_req_o}, 32'd1);
        step();
        chk("sw_c8_stall", {31'b0, stall_req_o}, 32'd0);
        chk("sw_c8_wreg", {31'b0, wreg_o}, 32'd0);
        chk("sw_nacc", acount - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("sw_addr", alog_addr[base + i], 32'h200 + i);
            chk("sw_data", {24'b0, alog_data[base + i]}, 32'h11 * (i + 1));
        end
        next_op();

        step();
        base = acount;
        set_instr(OPC_STORE, F3_SW, 32'h300, 5'd2, 1'b1, 32'hDEADBEEF);
        #1;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rstb_req", {31'b0, mem_req_o}, 32'd0);
        chk("rstb_stall", {31'b0, stall_req_o}, 32'd0);
        chk("rstb_addr", mem_a_o, 32'd0);
        chk("rstb_wdata", wdata_o, 32'd0);
        chk("rstb_wd", {27'b0, wd_o}, 32'd0);
        step();
        step();
        rst = 1'b1;
        set_instr(OPC_OP, 3'b000, 32'h0, 5'd4, 1'b1, 32'h77);
        #1;
        chk("rstb_idle_stall", {31'b0, stall_req_o}, 32'd0);
        chk("rstb_idle_wdata", wdata_o, 32'h77);
        step();
        step();
        chk("rstb_nwrites", acount - base, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
